// File: rtl/dram_rx_pkg.sv
// Shared definitions for the DRAM read-capture path: burst geometry, capture
// states and the beat-to-word bit-slice mapping.
package dram_rx_pkg;

  localparam int unsigned BL            = 4;
  localparam int unsigned BEATS_PER_CLK = 2;

  typedef enum logic [1:0] {
    IDLE,
    BEAT01,
    BEAT23
  } cap_state_e;

  // Beat k of a burst occupies word bits [beat_lsb(k)+dq_w-1 : beat_lsb(k)].
  function automatic int unsigned beat_lsb(input int unsigned beat, input int unsigned dq_w);
    return beat * dq_w;
  endfunction

endpackage

// File: rtl/dram_rd_fifo.sv
// Synchronous read-data FIFO with valid/ready output; a push while full is
// accepted when the head is popped in the same cycle.
module dram_rd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop, accept;

  assign rd_valid = (wptr_q != rptr_q);
  assign full     = ((wptr_q ^ rptr_q) == (AW + 1)'(DEPTH));
  assign pop      = rd_valid & pop_ready;
  assign accept   = push & (~full | pop);
  // Gated so the output is zero after reset rather than stale storage.
  assign rd_data  = rd_valid ? mem_q[rptr_q[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (accept) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop)    rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dram_rd_capture.sv
// DDR read capture: times bursts from rd_cmd via a latency wheel, packs four
// rise/fall beats into a word and queues it for the controller core.
module dram_rd_capture
  import dram_rx_pkg::*;
#(
  parameter int unsigned DQ_W  = 4,
  parameter int unsigned LAT_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_enable,
  input  logic               rd_cmd,
  input  logic [LAT_W-1:0]   rd_lat,
  input  logic [DQ_W-1:0]    dq_rise,
  input  logic [DQ_W-1:0]    dq_fall,
  output logic [BL*DQ_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               busy,
  output logic               overflow,
  output logic               collision
);

  localparam int unsigned W      = 2 ** LAT_W;
  localparam int unsigned WORD_W = BL * DQ_W;

  logic [W-1:0]                         wheel_q, wheel_d, wheel_shift, cmd_bit;
  logic [LAT_W-1:0]                     lat_eff;
  logic                                 rd_go, start, wheel_coll, start_coll;
  cap_state_e                           state_q, state_d;
  logic [BEATS_PER_CLK-1:0][DQ_W-1:0]   early_q, early_d, late;
  logic [WORD_W-1:0]                    word;
  logic                                 push, fifo_full, drop;
  logic                                 overflow_q, collision_q;

  assign lat_eff     = (rd_lat == '0) ? LAT_W'(1) : rd_lat;
  assign rd_go       = rd_cmd & capture_enable;
  assign wheel_shift = wheel_q >> 1;
  assign cmd_bit     = W'(1) << (lat_eff - 1'b1);
  assign wheel_coll  = rd_go & wheel_shift[lat_eff - 1'b1];
  assign wheel_d     = capture_enable ? (wheel_shift | (rd_go ? cmd_bit : '0)) : '0;
  assign start       = wheel_q[0] & capture_enable;
  assign late        = {dq_fall, dq_rise};

  always_comb begin
    state_d    = state_q;
    early_d    = early_q;
    push       = 1'b0;
    start_coll = 1'b0;
    if (!capture_enable) begin
      state_d = IDLE;
      early_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = BEAT01;
            early_d = late;
          end
        end
        BEAT01: begin
          // A start here would overlap the burst in flight; it is dropped.
          state_d    = BEAT23;
          push       = 1'b1;
          start_coll = start;
        end
        BEAT23: begin
          if (start) begin
            state_d = BEAT01;
            early_d = late;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < BEATS_PER_CLK; k++) begin : g_pack
    assign word[beat_lsb(k, DQ_W) +: DQ_W]                 = early_q[k];
    assign word[beat_lsb(k + BEATS_PER_CLK, DQ_W) +: DQ_W] = late[k];
  end

  assign drop = push & fifo_full & ~(rd_valid & rd_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wheel_q     <= '0;
      state_q     <= IDLE;
      early_q     <= '0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      wheel_q     <= wheel_d;
      state_q     <= state_d;
      early_q     <= early_d;
      overflow_q  <= overflow_q | drop;
      collision_q <= collision_q | wheel_coll | start_coll;
    end
  end

  dram_rd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word),
    .pop_ready (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (fifo_full)
  );

  assign busy      = (|wheel_q) | (state_q == BEAT01);
  assign overflow  = overflow_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dram_rd_capture.sv
// Self-checking bench for dram_rd_capture: table-driven single reads plus
// hand-written multi-cycle sequences, with a scoreboard on the output handshake.
module tb_dram_rd_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_enable, rd_cmd, rd_ready;
  logic [3:0]  rd_lat, dq_rise, dq_fall;
  logic [15:0] rd_data;
  logic        rd_valid, busy, overflow, collision;

  logic        en_v  = 1'b1;
  logic        rdy_v = 1'b1;
  logic [3:0]  lat_v = 4'd1;

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_q[$];

  dram_rd_capture #(
    .DQ_W  (4),
    .LAT_W (4),
    .DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .capture_enable (capture_enable),
    .rd_cmd         (rd_cmd),
    .rd_lat         (rd_lat),
    .dq_rise        (dq_rise),
    .dq_fall        (dq_fall),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .busy           (busy),
    .overflow       (overflow),
    .collision      (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle with the given inputs; returns mid-cycle (negedge) for sampling.
  task automatic cyc(input logic cmd, input logic [3:0] r, input logic [3:0] f);
    @(posedge clk);
    #1;
    rd_cmd         = cmd;
    dq_rise        = r;
    dq_fall        = f;
    capture_enable = en_v;
    rd_ready       = rdy_v;
    rd_lat         = lat_v;
    @(negedge clk);
  endtask

  task automatic idle(input logic cmd);
    cyc(cmd, 4'($urandom), 4'($urandom));
  endtask

  task automatic burst1(input logic [3:0] r0, input logic [3:0] f0,
                        input logic [3:0] r1, input logic [3:0] f1);
    idle(1'b1);
    cyc(1'b0, r0, f0);
    cyc(1'b0, r1, f1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every word the core accepts must be the next expected one.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", rd_data, $time);
      end else begin
        chk("scoreboard_word", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [3:0]  lat;
    logic [3:0]  r0, f0, r1, f1;
    int          le;
    logic [15:0] word;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{lat: 4'd3,  r0: 4'h1, f0: 4'h2, r1: 4'h3, f1: 4'h4, le: 3,  word: 16'h4321};
    tv[1] = '{lat: 4'd0,  r0: 4'h5, f0: 4'h6, r1: 4'h7, f1: 4'h8, le: 1,  word: 16'h8765};
    tv[2] = '{lat: 4'd1,  r0: 4'h9, f0: 4'ha, r1: 4'hb, f1: 4'hc, le: 1,  word: 16'hcba9};
    tv[3] = '{lat: 4'd2,  r0: 4'hf, f0: 4'h0, r1: 4'hf, f1: 4'h0, le: 2,  word: 16'h0f0f};
    tv[4] = '{lat: 4'd15, r0: 4'ha, f0: 4'h5, r1: 4'h3, f1: 4'hc, le: 15, word: 16'hc35a};
    tv[5] = '{lat: 4'd7,  r0: 4'h0, f0: 4'hf, r1: 4'h1, f1: 4'he, le: 7,  word: 16'he1f0};

    rst = 1'b1;
    capture_enable = 1'b1;
    rd_cmd = 1'b0;
    rd_ready = 1'b1;
    rd_lat = 4'd1;
    dq_rise = '0;
    dq_fall = '0;
    @(negedge clk);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_collision", 32'(collision), 0);
    rst = 1'b0;
    repeat (2) idle(1'b0);

    // Single reads across latencies, including rd_lat=0 and the maximum.
    foreach (tv[i]) begin
      lat_v = tv[i].lat;
      exp_q.push_back(tv[i].word);
      idle(1'b1);
      for (int c = 0; c < tv[i].le - 1; c++) idle(1'b0);
      cyc(1'b0, tv[i].r0, tv[i].f0);
      chk("single_busy_sample", 32'(busy), 1);
      cyc(1'b0, tv[i].r1, tv[i].f1);
      chk("single_valid_early", 32'(rd_valid), 0);
      idle(1'b0);
      chk("single_valid_on_time", 32'(rd_valid), 1);
      chk("single_rd_data", 32'(rd_data), 32'(tv[i].word));
      chk("single_busy_done", 32'(busy), 0);
      idle(1'b0);
    end

    // Back-to-back bursts, rd_lat=2, commands two cycles apart.
    lat_v = 4'd2;
    exp_q.push_back(16'h2c1b);
    exp_q.push_back(16'h5e6d);
    idle(1'b1);
    idle(1'b0);
    cyc(1'b1, 4'hb, 4'h1);
    cyc(1'b0, 4'hc, 4'h2);
    cyc(1'b0, 4'hd, 4'h6);
    chk("b2b_first_valid", 32'(rd_valid), 1);
    cyc(1'b0, 4'he, 4'h5);
    idle(1'b0);
    chk("b2b_second_valid", 32'(rd_valid), 1);
    idle(1'b0);
    chk("b2b_collision", 32'(collision), 0);
    chk("b2b_drained", 32'(rd_valid), 0);

    // Start arriving mid-burst: only the earlier command is captured.
    exp_q.push_back(16'h7a3a);
    idle(1'b1);
    idle(1'b1);
    cyc(1'b0, 4'ha, 4'h3);
    cyc(1'b0, 4'ha, 4'h7);
    idle(1'b0);
    chk("coll_flag", 32'(collision), 1);
    chk("coll_one_word", 32'(rd_valid), 1);
    idle(1'b0);
    chk("coll_no_second", 32'(rd_valid), 0);
    idle(1'b0);
    chk("coll_still_empty", 32'(rd_valid), 0);

    // Two commands landing on the same wheel slot.
    do_reset();
    chk("slot_coll_cleared", 32'(collision), 0);
    exp_q.push_back(16'h9876);
    lat_v = 4'd3;
    idle(1'b1);
    lat_v = 4'd2;
    idle(1'b1);
    idle(1'b0);
    chk("slot_coll_flag", 32'(collision), 1);
    cyc(1'b0, 4'h6, 4'h7);
    cyc(1'b0, 4'h8, 4'h9);
    idle(1'b0);
    chk("slot_coll_valid", 32'(rd_valid), 1);
    idle(1'b0);
    chk("slot_coll_single", 32'(rd_valid), 0);

    // Overflow: five bursts into a four-entry FIFO with no pops.
    lat_v = 4'd1;
    rdy_v = 1'b0;
    for (int b = 0; b < 5; b++) begin
      logic [15:0] w;
      w = 16'h1000 * 16'(b + 1) + 16'h0321;
      if (b < 4) exp_q.push_back(w);
      burst1(w[3:0], w[7:4], w[11:8], w[15:12]);
    end
    idle(1'b0);
    chk("ovf_valid", 32'(rd_valid), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(rd_data), 32'h1321);
    // Push while full, with a pop in the same cycle, must be accepted.
    exp_q.push_back(16'hbeef);
    idle(1'b1);
    cyc(1'b0, 4'hf, 4'he);
    rdy_v = 1'b1;
    cyc(1'b0, 4'he, 4'hb);
    repeat (5) idle(1'b0);
    chk("ovf_drained", 32'(rd_valid), 0);
    chk("ovf_queue_empty", 32'(exp_q.size()), 0);

    // Abort during BEAT01 keeps earlier FIFO contents intact.
    rdy_v = 1'b0;
    exp_q.push_back(16'h5a5a);
    burst1(4'ha, 4'h5, 4'ha, 4'h5);
    idle(1'b1);
    cyc(1'b0, 4'h1, 4'h1);
    en_v = 1'b0;
    idle(1'b0);
    en_v = 1'b1;
    idle(1'b0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_fifo_kept", 32'(rd_valid), 1);
    en_v = 1'b0;
    idle(1'b1);
    en_v = 1'b1;
    idle(1'b0);
    chk("disabled_cmd_busy", 32'(busy), 0);
    idle(1'b0);
    idle(1'b0);
    chk("disabled_cmd_no_start", 32'(busy), 0);
    rdy_v = 1'b1;
    repeat (3) idle(1'b0);
    chk("abort_drained", 32'(rd_valid), 0);
    chk("abort_queue_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-burst clears everything without a clock edge.
    rdy_v = 1'b0;
    exp_q.push_back(16'h3c3c);
    burst1(4'hc, 4'h3, 4'hc, 4'h3);
    idle(1'b1);
    cyc(1'b0, 4'h4, 4'h4);
    @(posedge clk);
    #1;
    rd_cmd = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_collision", 32'(collision), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idle(1'b0);
    chk("arst_no_partial", 32'(rd_valid), 0);
    chk("arst_idle", 32'(busy), 0);

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, expected completion");
    $fatal(1);
  end

endmodule
